// File: rtl/de2_audio_pkg.sv
// Shared audio-path definitions: receiver FSM encoding and default link parameters.
package de2_audio_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_LEFT  = 2'd1,
      RX_RIGHT = 2'd2
   } rx_state_e;

   localparam int AUDIO_DATA_W  = 16;
   localparam int I2S_DELAY_I2S = 1;
   localparam int I2S_DELAY_LJ  = 0;

endpackage

// File: rtl/adc_receiver_if.sv
// Sample-pair output bus of the ADC receiver: held pair, valid/ready, overrun control.
interface adc_receiver_if
   import de2_audio_pkg::*;
#(
   parameter int DATA_W = AUDIO_DATA_W
);
   logic [DATA_W-1:0] left_out;
   logic [DATA_W-1:0] right_out;
   logic              valid;
   logic              ready;
   logic              overrun;
   logic              clear_ovr;

   modport master (
      output left_out, right_out, valid, overrun,
      input  ready, clear_ovr
   );

   modport slave (
      input  left_out, right_out, valid, overrun,
      output ready, clear_ovr
   );
endinterface

// File: rtl/adc_receiver_sync_edge.sv
// 2-flop synchroniser for a small input bundle. Bit 0 additionally gets a registered
// rising-edge pulse; the remaining bits are passed out as plain synchronised levels.
module sync_edge #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-2:0] q_o,
   output logic         rise_o
);
   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic         prev_q;
   logic         rise_q;

   // two-stage sync, then edge detect on bit 0 registered into a one-cycle pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q[0];
         rise_q <= sync_q[0] & ~prev_q;
      end
   end

   assign q_o    = sync_q[W-1:1];
   assign rise_o = rise_q;
endmodule

// File: rtl/adc_receiver.sv
// Codec ADC serial receiver: recovers BCLK/LRCK/DAT in the clk domain, deserialises
// MSB-first stereo slots and presents left/right pairs on a valid/ready bus.
module adc_receiver
   import de2_audio_pkg::*;
#(
   parameter int DATA_W    = AUDIO_DATA_W,
   parameter int I2S_DELAY = I2S_DELAY_I2S
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          bclk,
   input  logic          adclrck,
   input  logic          adcdat,
   adc_receiver_if.master rx
);
   localparam int CNT_MAX = DATA_W + I2S_DELAY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

   // counter saturates at the end of the capture window so long slots never wrap
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
      return (c == CNT_W'(CNT_MAX)) ? c : c + 1'b1;
   endfunction

   // places the bit at its MSB-first position; short slots stay left-aligned, zero-padded
   function automatic logic [DATA_W-1:0] sh_next(input logic [CNT_W-1:0] c,
                                                 input logic [DATA_W-1:0] sh,
                                                 input logic d);
      logic [DATA_W-1:0] m;
      logic [DATA_W-1:0] r;
      r = sh;
      m = MSB_ONE >> (c - CNT_W'(I2S_DELAY));
      if (int'(c) >= I2S_DELAY && int'(c) < CNT_MAX)
         r = d ? (sh | m) : (sh & ~m);
      return r;
   endfunction

   logic [1:0] sync_lvl;
   logic       bclk_rise;
   logic       lrck_s;
   logic       dat_s;

   sync_edge #(.W(3)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    ({adcdat, adclrck, bclk}),
      .q_o    (sync_lvl),
      .rise_o (bclk_rise)
   );

   assign lrck_s = sync_lvl[0];
   assign dat_s  = sync_lvl[1];

   rx_state_e         state_q;
   logic              seen_hi_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] lsh_q;
   logic [DATA_W-1:0] rsh_q;

   logic [DATA_W-1:0] left_q,  left_d;
   logic [DATA_W-1:0] right_q, right_d;
   logic              valid_q, valid_d;
   logic              ovr_q,   ovr_d;
   logic              commit;
   logic              ovr_set;

   // a pair completes on the BCLK edge that sees LRCK return low after the right slot
   assign commit  = en & bclk_rise & (state_q == RX_RIGHT) & ~lrck_s;
   assign ovr_set = commit & valid_q & ~rx.ready;

   // slot tracking FSM; the LRCK-change edge is event 0 of the new slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RX_IDLE;
         seen_hi_q <= 1'b0;
         cnt_q     <= '0;
         lsh_q     <= '0;
         rsh_q     <= '0;
      end else if (!en) begin
         state_q   <= RX_IDLE;
         seen_hi_q <= 1'b0;
         cnt_q     <= '0;
         lsh_q     <= '0;
         rsh_q     <= '0;
      end else if (bclk_rise) begin
         case (state_q)
            RX_IDLE: begin
               if (lrck_s) begin
                  seen_hi_q <= 1'b1;
               end else if (seen_hi_q) begin
                  state_q   <= RX_LEFT;
                  seen_hi_q <= 1'b0;
                  cnt_q     <= cnt_next('0);
                  lsh_q     <= sh_next('0, '0, dat_s);
               end
            end
            RX_LEFT: begin
               if (lrck_s) begin
                  state_q <= RX_RIGHT;
                  cnt_q   <= cnt_next('0);
                  rsh_q   <= sh_next('0, '0, dat_s);
               end else begin
                  cnt_q <= cnt_next(cnt_q);
                  lsh_q <= sh_next(cnt_q, lsh_q, dat_s);
               end
            end
            RX_RIGHT: begin
               if (!lrck_s) begin
                  state_q <= RX_LEFT;
                  cnt_q   <= cnt_next('0);
                  lsh_q   <= sh_next('0, '0, dat_s);
               end else begin
                  cnt_q <= cnt_next(cnt_q);
                  rsh_q <= sh_next(cnt_q, rsh_q, dat_s);
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   // output pair, valid and sticky overrun next-state
   always_comb begin
      left_d  = left_q;
      right_d = right_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (commit) begin
         if (!valid_q || rx.ready) begin
            left_d  = lsh_q;
            right_d = rsh_q;
            valid_d = 1'b1;
         end
      end else if (valid_q && rx.ready) begin
         valid_d = 1'b0;
      end
      if (ovr_set)           ovr_d = 1'b1;
      else if (rx.clear_ovr) ovr_d = 1'b0;
   end

   // handshake registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         left_q  <= '0;
         right_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         left_q  <= left_d;
         right_q <= right_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx.left_out  = left_q;
   assign rx.right_out = right_q;
   assign rx.valid     = valid_q;
   assign rx.overrun   = ovr_q;
endmodule

// File: tb/tb_adc_receiver.sv
// Bench for adc_receiver: an I2S instance and a left-justified instance, frames driven
// bit by bit, expected pairs pushed on send and matched against pairs seen consumed.
module tb_adc_receiver;
   import de2_audio_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic en,  bclk,  lrck,  dat;
   logic en2, bclk2, lrck2, dat2;

   adc_receiver_if #(.DATA_W(16)) rx  ();
   adc_receiver_if #(.DATA_W(16)) rx2 ();

   adc_receiver #(.DATA_W(16), .I2S_DELAY(I2S_DELAY_I2S)) dut (
      .clk(clk), .reset(reset), .en(en), .bclk(bclk),
      .adclrck(lrck), .adcdat(dat), .rx(rx)
   );

   adc_receiver #(.DATA_W(16), .I2S_DELAY(I2S_DELAY_LJ)) dut2 (
      .clk(clk), .reset(reset), .en(en2), .bclk(bclk2),
      .adclrck(lrck2), .adcdat(dat2), .rx(rx2)
   );

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] exp2_q[$];
   logic [31:0] got2_q[$];
   logic [31:0] e, g;
   int pass_cnt = 0;
   int total_cnt = 0;

   // one clock; pairs consumed at the coming edge are recorded at the negedge before it
   task automatic wait_clk();
      @(negedge clk);
      if (rx.valid && rx.ready)   got_q.push_back({rx.left_out, rx.right_out});
      if (rx2.valid && rx2.ready) got2_q.push_back({rx2.left_out, rx2.right_out});
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input bit w, input logic l, input logic d);
      if (!w) begin bclk = 1'b0; lrck = l; dat = d; end
      else    begin bclk2 = 1'b0; lrck2 = l; dat2 = d; end
      repeat (8) wait_clk();
      if (!w) bclk = 1'b1; else bclk2 = 1'b1;
      repeat (8) wait_clk();
   endtask

   task automatic send_slot(input bit w, input logic l, input logic [15:0] v,
                            input int nb, input int dly, input int pad);
      logic [15:0] s;
      s = v;
      for (int i = 0; i < dly; i++) send_bit(w, l, 1'($urandom));
      for (int i = 0; i < nb; i++) begin
         send_bit(w, l, s[15]);
         s = s << 1;
      end
      for (int i = 0; i < pad; i++) send_bit(w, l, 1'($urandom));
   endtask

   task automatic send_frame(input bit w, input logic [15:0] l, input logic [15:0] r,
                             input int nb, input int dly, input int pad);
      send_slot(w, 1'b0, l, nb, dly, pad);
      send_slot(w, 1'b1, r, nb, dly, pad);
   endtask

   // force IDLE, then show a right-slot sample so the next low LRCK starts a frame
   task automatic restart(input bit w);
      if (!w) en = 1'b0; else en2 = 1'b0;
      repeat (2) wait_clk();
      if (!w) en = 1'b1; else en2 = 1'b1;
      send_bit(w, 1'b1, 1'b0);
      send_bit(w, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         en = 1'($urandom); bclk = 1'($urandom); lrck = 1'($urandom); dat = 1'($urandom);
         rx.ready = 1'($urandom); rx.clear_ovr = 1'($urandom);
         @(posedge clk); #1;
      end
      total_cnt++; if (rx.left_out !== 16'h0) $display("FAIL reset_left: got %h want 0000", rx.left_out); else pass_cnt++;
      total_cnt++; if (rx.right_out !== 16'h0) $display("FAIL reset_right: got %h want 0000", rx.right_out); else pass_cnt++;
      total_cnt++; if (rx.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx.valid); else pass_cnt++;
      total_cnt++; if (rx.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", rx.overrun); else pass_cnt++;
      en = 1'b1; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
      rx.ready = 1'b1; rx.clear_ovr = 1'b0;
      reset = 1'b1;
      repeat (20) wait_clk();
      total_cnt++; if (rx.valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", rx.valid); else pass_cnt++;
      total_cnt++; if (got_q.size() !== 0) $display("FAIL post_reset_pairs: got %0d want 0", got_q.size()); else pass_cnt++;
   endtask

   task automatic test_i2s_frame();
      rx.ready = 1'b1;
      restart(1'b0);
      send_frame(1'b0, 16'hA5C3, 16'h3C5A, 16, 1, 1);
      exp_q.push_back({16'hA5C3, 16'h3C5A});
      // frame-ending BCLK edge, watched clock by clock
      bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
      repeat (8) wait_clk();
      bclk = 1'b1;
      repeat (3) wait_clk();
      total_cnt++; if (rx.valid !== 1'b0) $display("FAIL i2s_valid_early: got %b want 0 at edge 3", rx.valid); else pass_cnt++;
      wait_clk();
      total_cnt++; if (rx.valid !== 1'b1) $display("FAIL i2s_valid_edge4: got %b want 1", rx.valid); else pass_cnt++;
      wait_clk();
      total_cnt++; if (rx.valid !== 1'b0) $display("FAIL i2s_valid_width: got %b want 0 after 1 cycle", rx.valid); else pass_cnt++;
      repeat (3) wait_clk();
      total_cnt++;
      if (got_q.size() !== 1) $display("FAIL i2s_count: got %0d pairs want 1", got_q.size());
      else begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         if (g !== e) $display("FAIL i2s_pair: got %h want %h", g, e); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      rx.ready = 1'b0;
      restart(1'b0);
      send_frame(1'b0, 16'h1111, 16'h2222, 16, 1, 1);
      exp_q.push_back({16'h1111, 16'h2222});
      send_frame(1'b0, 16'h3333, 16'h4444, 16, 1, 1);
      send_bit(1'b0, 1'b0, 1'b0);
      total_cnt++; if (rx.valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", rx.valid); else pass_cnt++;
      total_cnt++; if (rx.overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", rx.overrun); else pass_cnt++;
      total_cnt++;
      if ({rx.left_out, rx.right_out} !== 32'h1111_2222)
         $display("FAIL bp_held_pair: got %h want 11112222", {rx.left_out, rx.right_out});
      else pass_cnt++;
      rx.ready = 1'b1;
      repeat (3) wait_clk();
      total_cnt++; if (rx.valid !== 1'b0) $display("FAIL bp_consumed: got valid %b want 0", rx.valid); else pass_cnt++;
      total_cnt++;
      if (got_q.size() !== 1) $display("FAIL bp_count: got %0d pairs want 1", got_q.size());
      else begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         if (g !== e) $display("FAIL bp_pair: got %h want %h", g, e); else pass_cnt++;
      end
      total_cnt++; if (rx.overrun !== 1'b1) $display("FAIL bp_overrun_sticky: got %b want 1", rx.overrun); else pass_cnt++;
      rx.clear_ovr = 1'b1;
      wait_clk();
      rx.clear_ovr = 1'b0;
      total_cnt++; if (rx.overrun !== 1'b0) $display("FAIL bp_clear_ovr: got %b want 0", rx.overrun); else pass_cnt++;
   endtask

   task automatic test_short_slot();
      rx.ready = 1'b1;
      restart(1'b0);
      send_frame(1'b0, 16'hABC0, 16'h1230, 12, 1, 0);
      exp_q.push_back({16'hABC0, 16'h1230});
      send_bit(1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (got_q.size() !== 1) $display("FAIL short_i2s_count: got %0d pairs want 1", got_q.size());
      else begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         if (g !== e) $display("FAIL short_i2s_pair: got %h want %h", g, e); else pass_cnt++;
      end
      rx2.ready = 1'b1;
      restart(1'b1);
      send_frame(1'b1, 16'hABC0, 16'h1230, 12, 0, 0);
      exp2_q.push_back({16'hABC0, 16'h1230});
      send_bit(1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (got2_q.size() !== 1) $display("FAIL short_lj_count: got %0d pairs want 1", got2_q.size());
      else begin
         e = exp2_q.pop_front(); g = got2_q.pop_front();
         if (g !== e) $display("FAIL short_lj_pair: got %h want %h", g, e); else pass_cnt++;
      end
      total_cnt++; if (rx2.overrun !== 1'b0) $display("FAIL short_lj_overrun: got %b want 0", rx2.overrun); else pass_cnt++;
   endtask

   task automatic test_en_drop();
      rx.ready = 1'b1;
      restart(1'b0);
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0, 1'($urandom));
      en = 1'b0;
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'($urandom));
      en = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'($urandom));
      send_slot(1'b0, 1'b1, 16'hDEAD, 16, 1, 1);
      send_frame(1'b0, 16'h7FFF, 16'h8000, 16, 1, 1);
      exp_q.push_back({16'h7FFF, 16'h8000});
      send_bit(1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (got_q.size() !== 1) $display("FAIL en_drop_count: got %0d pairs want 1", got_q.size());
      else begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         if (g !== e) $display("FAIL en_drop_pair: got %h want %h", g, e); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      rx.ready = 1'b0;
      restart(1'b0);
      send_frame(1'b0, 16'h5A5A, 16'hA5A5, 16, 1, 1);
      send_slot(1'b0, 1'b0, 16'h0F0F, 16, 1, 1);
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b1);
      total_cnt++; if (rx.valid !== 1'b1) $display("FAIL rmid_valid_before: got %b want 1", rx.valid); else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      total_cnt++;
      if ({rx.left_out, rx.right_out, rx.valid, rx.overrun} !== 34'h0)
         $display("FAIL rmid_async_clear: got %h/%h v%b o%b want 0/0 v0 o0",
                  rx.left_out, rx.right_out, rx.valid, rx.overrun);
      else pass_cnt++;
      repeat (2) wait_clk();
      reset = 1'b1;
      exp_q.delete();
      rx.ready = 1'b1;
      for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b1, 1'b1);
      send_frame(1'b0, 16'h1234, 16'hFEDC, 16, 1, 1);
      exp_q.push_back({16'h1234, 16'hFEDC});
      send_bit(1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (got_q.size() !== 1) $display("FAIL rmid_count: got %0d pairs want 1", got_q.size());
      else begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         if (g !== e) $display("FAIL rmid_pair: got %h want %h", g, e); else pass_cnt++;
      end
      total_cnt++; if (rx.overrun !== 1'b0) $display("FAIL rmid_overrun: got %b want 0", rx.overrun); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0;
      en = 1'b0; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
      en2 = 1'b1; bclk2 = 1'b0; lrck2 = 1'b0; dat2 = 1'b0;
      rx.ready = 1'b1; rx.clear_ovr = 1'b0;
      rx2.ready = 1'b1; rx2.clear_ovr = 1'b0;
      test_reset();
      test_i2s_frame();
      test_backpressure();
      test_short_slot();
      test_en_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
